uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous serial line into parallel bytes using the oversampling tick from the baud generator. It sits directly downstream of the baud generator's receive tick and upstream of any byte consumer, such as a FIFO or register file. It presents each received byte on a valid/ready holding register with frame, parity and overrun status.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    RECOVER
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready holding register and frame/parity/overrun status.
// Even parity bit is added to the frame when UART_RX_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | line idle, waiting for a low sample
// START   | half-bit wait, re-check start bit (glitch filter)
// DATA    | one full bit per data bit, LSB first
// PARITY  | one full bit, sample even parity (UART_RX_PARITY_EN only)
// STOP    | one full bit, sample stop; frame completes here
// RECOVER | stop was low; wait for line high so a break is one frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE_RATE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE_RATE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] HALF_TC = TICK_W'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_TC = TICK_W'(OVERSAMPLE_RATE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 frame_done;
  logic                 frame_err_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_n;
`endif

  uart_sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_cnt;
    shift_n     = shift;
    frame_done  = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n   = par_err_q;
`endif
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_TC) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_TC) begin
            tick_n  = '0;
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == FULL_TC) begin
            tick_n    = '0;
            par_err_n = rx_s ^ (^shift);
            state_n   = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == FULL_TC) begin
            tick_n      = '0;
            frame_done  = 1'b1;
            frame_err_n = !rx_s;
            state_n     = rx_s ? IDLE : RECOVER;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A completing frame may load in the same cycle the old byte is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data      <= shift;
          rx_frame_err <= frame_err_n;
          rx_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
          rx_parity_err <= par_err_q;
`endif
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DATA_BITS=8, OVERSAMPLE_RATE=8.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DATA_BITS = 8;
  localparam int OS        = 8;
  localparam int TICK_DIV  = 4;
  localparam int BIT_CLKS  = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun;

  int errors = 0;
  int checks = 0;

  int         valid_cycles = 0;
  int         acc_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] acc_data = '0;
  logic       acc_ferr = 1'b0;
  logic       acc_perr = 1'b0;
  int         div = 0;

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE_RATE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_tick       (rx_tick),
    .rx_serial     (rx_serial),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= (div == TICK_DIV - 1) ? 0 : div + 1;
    rx_tick <= (div == TICK_DIV - 1);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        acc_data = rx_data;
        acc_ferr = rx_frame_err;
        acc_perr = rx_parity_err;
      end
      if (rx_overrun) ovr_cnt++;
    end
  end

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input int stop_low_bits);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    for (int i = 0; i < stop_low_bits; i++) drive_bit(1'b0);
    drive_bit(1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_err); end
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", rx_parity_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", rx_overrun); end
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] vec [4];
    int vc0, ac0, oc0;
    vec = '{8'hA5, 8'h00, 8'hFF, 8'h96};
    rx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vc0 = valid_cycles; ac0 = acc_cnt; oc0 = ovr_cnt;
      send_frame(vec[k], ^vec[k], 0);
      drive_bit(1'b1);
      checks++; if (valid_cycles - vc0 != 1) begin errors++; $display("FAIL basic_valid_cycles[%0d] got=%0d exp=1", k, valid_cycles - vc0); end
      checks++; if (acc_cnt - ac0 != 1) begin errors++; $display("FAIL basic_accepts[%0d] got=%0d exp=1", k, acc_cnt - ac0); end
      checks++; if (acc_data !== vec[k]) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", k, acc_data, vec[k]); end
      checks++; if (acc_ferr !== 1'b0 || acc_perr !== 1'b0) begin errors++; $display("FAIL basic_flags[%0d] got=%b%b exp=00", k, acc_ferr, acc_perr); end
      checks++; if (ovr_cnt != oc0) begin errors++; $display("FAIL basic_ovr[%0d] got=%0d exp=0", k, ovr_cnt - oc0); end
    end
  endtask

  task automatic test_glitch;
    int vc0;
    vc0 = valid_cycles;
    rx_serial = 1'b0;
    repeat (2) @(posedge rx_tick);
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (7) @(posedge rx_tick);
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state, IDLE); end
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (valid_cycles != vc0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cycles - vc0); end
  endtask

  task automatic test_frame_err;
    int ac0;
    ac0 = acc_cnt;
    rx_ready = 1'b1;
    send_frame(8'h3C, ^8'h3C, 3);
    drive_bit(1'b1);
    checks++; if (acc_cnt - ac0 != 1) begin errors++; $display("FAIL ferr_accepts got=%0d exp=1", acc_cnt - ac0); end
    checks++; if (acc_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got=%h exp=3c", acc_data); end
    checks++; if (acc_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", acc_ferr); end
    ac0 = acc_cnt;
    send_frame(8'h55, ^8'h55, 0);
    drive_bit(1'b1);
    checks++; if (acc_cnt - ac0 != 1) begin errors++; $display("FAIL ferr_next_accepts got=%0d exp=1", acc_cnt - ac0); end
    checks++; if (acc_data !== 8'h55 || acc_ferr !== 1'b0) begin errors++; $display("FAIL ferr_next got=%h/%b exp=55/0", acc_data, acc_ferr); end
  endtask

  task automatic test_overrun;
    int oc0;
    logic seen;
    rx_ready = 1'b0;
    oc0 = ovr_cnt;
    send_frame(8'h11, ^8'h11, 0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first got=%b/%h exp=1/11", rx_valid, rx_data); end
    send_frame(8'h22, ^8'h22, 0);
    checks++; if (ovr_cnt - oc0 != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - oc0); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_kept got=%b/%h exp=1/11", rx_valid, rx_data); end
    oc0 = ovr_cnt;
    seen = 1'b0;
    fork
      send_frame(8'h33, ^8'h33, 0);
      begin
        for (int i = 0; i < BIT_CLKS * 12 && !seen; i++) begin
          @(negedge clk);
          rx_ready = dut.frame_done;
          if (dut.frame_done) seen = 1'b1;
        end
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ovr_complete_timeout got=%b exp=1", seen); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin errors++; $display("FAIL ovr_same_cycle got=%b/%h exp=1/33", rx_valid, rx_data); end
    checks++; if (ovr_cnt != oc0) begin errors++; $display("FAIL ovr_same_cycle_pulse got=%0d exp=0", ovr_cnt - oc0); end
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", rx_valid); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    rx_ready = 1'b1;
    send_frame(8'h07, 1'b0, 0);
    drive_bit(1'b1);
    checks++; if (acc_data !== 8'h07 || acc_perr !== 1'b1) begin errors++; $display("FAIL parity_bad got=%h/%b exp=07/1", acc_data, acc_perr); end
    send_frame(8'h07, 1'b1, 0);
    drive_bit(1'b1);
    checks++; if (acc_data !== 8'h07 || acc_perr !== 1'b0) begin errors++; $display("FAIL parity_good got=%h/%b exp=07/0", acc_data, acc_perr); end
  endtask
`endif

  task automatic test_reset_mid;
    int ac0;
    rx_ready = 1'b1;
    fork
      send_frame(8'hFF, ^8'hFF, 0);
      begin
        repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun} !== 12'h000) begin
          errors++; $display("FAIL midreset_outputs got=%h/%b%b%b%b exp=00/0000", rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun);
        end
        reset = 1'b0;
      end
    join
    ac0 = acc_cnt;
    drive_bit(1'b1);
    checks++; if (acc_cnt != ac0 || rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_discard got=%0d/%b exp=0/0", acc_cnt - ac0, rx_valid); end
    send_frame(8'h81, ^8'h81, 0);
    drive_bit(1'b1);
    checks++; if (acc_cnt - ac0 != 1 || acc_data !== 8'h81) begin errors++; $display("FAIL midreset_next got=%0d/%h exp=1/81", acc_cnt - ac0, acc_data); end
    checks++; if (acc_ferr !== 1'b0 || acc_perr !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b exp=00", acc_ferr, acc_perr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
